// File: rtl/exe_stage_pkg.sv
// Shared bus layouts, ALU opcode bit positions and divider state type for the
// execute stage of the in-order LoongArch pipeline.
package exe_stage_pkg;

  localparam int DIV_CYCLES      = 32;
  localparam int DS_TO_ES_BUS_WD = 151;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ES_TO_DS_FWD_WD = 40;

  // Bit positions inside the one-hot alu_op field.
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [11:0] alu_op;
    logic        div_en;
    logic        div_signed;
    logic        div_rem;
    logic        load_op;
    logic        mem_we;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic [31:0] pc;
  } ds_to_es_t;

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_to_ms_t;

endpackage

// File: rtl/exe_stage_div_iter.sv
// Restoring radix-2 divider with fixed DIV_CYCLES latency; operands are divided
// as magnitudes and the signs are re-applied on the way out.
//
// state    | meaning
// DIV_IDLE | waiting for start, operands not yet captured
// DIV_BUSY | one quotient bit per cycle, cnt counts down to terminal 0
// DIV_DONE | result held on quotient/remainder until ack
module div_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ack,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rem, quo, dvs, abs_a, abs_b;
  logic [32:0]      r_sh, diff;
  logic             neg_q, neg_r, by_zero;

  assign abs_a = (is_signed && a[31]) ? (~a + 32'd1) : a;
  assign abs_b = (is_signed && b[31]) ? (~b + 32'd1) : b;
  assign r_sh  = {rem, quo[31]};
  assign diff  = r_sh - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start)      state_nxt = DIV_BUSY;
      DIV_BUSY: if (cnt == '0)  state_nxt = DIV_DONE;
      DIV_DONE: if (ack)        state_nxt = DIV_IDLE;
      default:                  state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      by_zero <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      cnt     <= CNT_W'(DIV_CYCLES - 1);
      rem     <= '0;
      quo     <= abs_a;
      dvs     <= abs_b;
      neg_q   <= is_signed && (a[31] ^ b[31]);
      neg_r   <= is_signed && a[31];
      by_zero <= (b == 32'd0);
    end else if (state == DIV_BUSY) begin
      cnt <= cnt - CNT_W'(1);
      rem <= diff[32] ? r_sh[31:0] : diff[31:0];
      quo <= {quo[30:0], ~diff[32]};
    end
  end

  // With a zero divisor rem ends up as |a|, so the sign fix-up returns a itself.
  assign done      = (state == DIV_DONE);
  assign quotient  = by_zero ? 32'hFFFF_FFFF : (neg_q ? (~quo + 32'd1) : quo);
  assign remainder = neg_r ? (~rem + 32'd1) : rem;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: one-hot ALU, iterative divider, data_sram request and the
// valid/allowin handshake towards mem_stage.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_TO_DS_FWD_WD-1:0] es_to_ds_fwd,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  ds_to_es_t   es_bus;
  es_to_ms_t   ms_bus;
  logic        es_valid, es_ready_go;
  logic        div_done;
  logic [31:0] quotient, remainder;
  logic [31:0] src1, src2, alu_result, es_result;
  logic [11:0] op;
  logic [4:0]  shamt;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
      es_bus   <= '0;
    end else begin
      if (es_allowin) es_valid <= ds_to_es_valid;
      if (ds_to_es_valid && es_allowin) es_bus <= ds_to_es_bus;
    end
  end

  assign es_ready_go    = !es_bus.div_en || div_done;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;

  assign src1  = es_bus.src1;
  assign src2  = es_bus.src2;
  assign op    = es_bus.alu_op;
  assign shamt = src2[4:0];

  always_comb begin
    alu_result = ({32{op[ALU_ADD]}}  & (src1 + src2))
               | ({32{op[ALU_SUB]}}  & (src1 - src2))
               | ({32{op[ALU_SLT]}}  & {31'd0, $signed(src1) < $signed(src2)})
               | ({32{op[ALU_SLTU]}} & {31'd0, src1 < src2})
               | ({32{op[ALU_AND]}}  & (src1 & src2))
               | ({32{op[ALU_NOR]}}  & ~(src1 | src2))
               | ({32{op[ALU_OR]}}   & (src1 | src2))
               | ({32{op[ALU_XOR]}}  & (src1 ^ src2))
               | ({32{op[ALU_SLL]}}  & (src1 << shamt))
               | ({32{op[ALU_SRL]}}  & (src1 >> shamt))
               | ({32{op[ALU_SRA]}}  & 32'($signed(src1) >>> shamt))
               | ({32{op[ALU_LUI]}}  & src2);
  end

  // Start is level-qualified inside div_iter by its IDLE state, so holding it
  // high while the instruction waits in DONE cannot re-launch the divide.
  div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (es_valid && es_bus.div_en),
    .is_signed (es_bus.div_signed),
    .a         (src1),
    .b         (src2),
    .ack       (es_to_ms_valid && ms_allowin),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign es_result = es_bus.div_en ? (es_bus.div_rem ? remainder : quotient) : alu_result;

  always_comb begin
    ms_bus              = '0;
    ms_bus.res_from_mem = es_bus.load_op;
    ms_bus.gr_we        = es_bus.gr_we;
    ms_bus.dest         = es_bus.dest;
    ms_bus.result       = es_result;
    ms_bus.pc           = es_bus.pc;
  end
  assign es_to_ms_bus = ms_bus;

  assign es_to_ds_fwd = {es_valid && es_bus.gr_we, es_valid && es_bus.load_op,
                         es_bus.dest, es_ready_go, es_result};

  assign data_sram_en    = es_valid && (es_bus.load_op || es_bus.mem_we) && es_ready_go && ms_allowin;
  assign data_sram_we    = {4{es_bus.mem_we && data_sram_en}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_bus.rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, divider latency/results, memory
// request under ms stall, and reset in the middle of a divide.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       ms_allowin;
  logic                       es_allowin;
  logic                       ds_to_es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [ES_TO_DS_FWD_WD-1:0] es_to_ds_fwd;
  logic                       data_sram_en;
  logic [3:0]                 data_sram_we;
  logic [31:0]                data_sram_addr;
  logic [31:0]                data_sram_wdata;

  int vectors = 0;
  int miscompares = 0;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_to_ds_fwd    (es_to_ds_fwd),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  // ALU table: op, src1, src2, hand-computed result
  int          alu_op_t [12] = '{ALU_SUB, ALU_SLT, ALU_SLT, ALU_SLTU, ALU_AND, ALU_NOR,
                                 ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI};
  logic [31:0] alu_s1_t [12] = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
                                 32'hF0F0_F0F0, 32'h1234_0000, 32'hFFFF_0000, 32'd1,
                                 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF};
  logic [31:0] alu_s2_t [12] = '{32'd7, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'hFF00_FF00,
                                 32'h0F0F_0F00, 32'h0000_5678, 32'h0F0F_0F0F, 32'h0000_0023,
                                 32'd4, 32'd4, 32'h1234_5000};
  logic [31:0] alu_ex_t [12] = '{32'hFFFF_FFFE, 32'd1, 32'd0, 32'd0, 32'hF000_F000,
                                 32'h0000_000F, 32'h1234_5678, 32'hF0F0_0F0F, 32'd8,
                                 32'h0800_0000, 32'hF800_0000, 32'h1234_5000};

  function automatic logic [DS_TO_ES_BUS_WD-1:0] mk(
    input int op, input logic dv, input logic sg, input logic rm,
    input logic ld, input logic we, input logic gr,
    input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rkd);
    ds_to_es_t t;
    t            = '0;
    t.alu_op     = 12'b1 << op;
    t.div_en     = dv;
    t.div_signed = sg;
    t.div_rem    = rm;
    t.load_op    = ld;
    t.mem_we     = we;
    t.gr_we      = gr;
    t.dest       = 5'd7;
    t.src1       = s1;
    t.src2       = s2;
    t.rkd_value  = rkd;
    t.pc         = 32'h1C00_0100;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one edge; returns in the instruction's first es cycle.
  task automatic issue(input logic [DS_TO_ES_BUS_WD-1:0] b);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    tick;
    ds_to_es_valid = 1'b0;
    #1;
  endtask

  // Called in a divide's first es cycle (cycle 0); stops in the cycle it is offered to ms.
  // Cycle 0 issues the start, BUSY occupies cycles 1..32, DONE shows in cycle 33.
  task automatic run_div(input string tag, input logic [31:0] exp);
    int lat = 0;
    int open = 0;
    while (es_to_ms_valid !== 1'b1 && lat < 40) begin
      if (es_allowin !== 1'b0) open++;
      if (es_to_ds_fwd[32] !== 1'b0) open++;
      tick;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd33);
    chk({tag, "_allowin_low"}, 32'(open), 32'd0);
    chk({tag, "_result"}, es_to_ms_bus[63:32], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    tick;
    tick;
    chk("rst_allowin", 32'(es_allowin), 32'd1);
    chk("rst_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
    chk("rst_sram_en", 32'(data_sram_en), 32'd0);
    chk("rst_sram_we", 32'(data_sram_we), 32'd0);
    reset = 1'b0;
    tick;

    // ADD with signed overflow wraps
    issue(mk(ALU_ADD, 0, 0, 0, 0, 0, 1, 32'h7FFF_FFFF, 32'd1, 32'd0));
    chk("add_valid", 32'(es_to_ms_valid), 32'd1);
    chk("add_result", es_to_ms_bus[63:32], 32'h8000_0000);
    chk("add_pc", es_to_ms_bus[31:0], 32'h1C00_0100);
    chk("add_dest", 32'(es_to_ms_bus[68:64]), 32'd7);
    chk("add_sram_en", 32'(data_sram_en), 32'd0);
    tick;
    chk("add_drained", 32'(es_to_ms_valid), 32'd0);

    for (int i = 0; i < 12; i++) begin
      issue(mk(alu_op_t[i], 0, 0, 0, 0, 0, 1, alu_s1_t[i], alu_s2_t[i], 32'd0));
      chk($sformatf("alu%0d_result", i), es_to_ms_bus[63:32], alu_ex_t[i]);
    end
    tick;

    // Store held by an ms stall for three cycles
    issue(mk(ALU_ADD, 0, 0, 0, 0, 1, 0, 32'h1000, 32'd8, 32'hDEAD_BEEF));
    ms_allowin = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("st_stall%0d_en", i), 32'(data_sram_en), 32'd0);
      chk($sformatf("st_stall%0d_allowin", i), 32'(es_allowin), 32'd0);
      chk($sformatf("st_stall%0d_valid", i), 32'(es_to_ms_valid), 32'd1);
      tick;
    end
    ms_allowin = 1'b1;
    #1;
    chk("st_en", 32'(data_sram_en), 32'd1);
    chk("st_we", 32'(data_sram_we), 32'hF);
    chk("st_addr", data_sram_addr, 32'h1008);
    chk("st_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    tick;
    chk("st_en_after", 32'(data_sram_en), 32'd0);

    // Load
    issue(mk(ALU_ADD, 0, 0, 0, 1, 0, 1, 32'h2000, 32'd4, 32'd0));
    chk("ld_en", 32'(data_sram_en), 32'd1);
    chk("ld_we", 32'(data_sram_we), 32'd0);
    chk("ld_addr", data_sram_addr, 32'h2004);
    chk("ld_res_from_mem", 32'(es_to_ms_bus[70]), 32'd1);
    chk("ld_fwd_flags", 32'(es_to_ds_fwd[39:38]), 32'd3);
    tick;

    // Divides
    issue(mk(ALU_ADD, 1, 1, 0, 0, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'd0));
    run_div("div_m7_2", 32'hFFFF_FFFD);
    issue(mk(ALU_ADD, 1, 1, 1, 0, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'd0));
    run_div("mod_m7_2", 32'hFFFF_FFFF);
    issue(mk(ALU_ADD, 1, 0, 0, 0, 0, 1, 32'h1234, 32'd0, 32'd0));
    run_div("divu_by0", 32'hFFFF_FFFF);
    issue(mk(ALU_ADD, 1, 0, 1, 0, 0, 1, 32'h1234, 32'd0, 32'd0));
    run_div("modu_by0", 32'h1234);
    issue(mk(ALU_ADD, 1, 1, 1, 0, 0, 1, 32'hFFFF_FFFB, 32'd0, 32'd0));
    run_div("mod_m5_by0", 32'hFFFF_FFFB);
    issue(mk(ALU_ADD, 1, 1, 0, 0, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0));
    run_div("div_min_m1", 32'h8000_0000);
    issue(mk(ALU_ADD, 1, 1, 1, 0, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0));
    run_div("mod_min_m1", 32'd0);
    tick;

    // Back-to-back: the second divide waits in decode while the first is busy
    issue(mk(ALU_ADD, 1, 0, 0, 0, 0, 1, 32'd100, 32'd7, 32'd0));
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(ALU_ADD, 1, 0, 1, 0, 0, 1, 32'd100, 32'd7, 32'd0);
    #1;
    run_div("b2b_first", 32'd14);
    tick;
    ds_to_es_valid = 1'b0;
    #1;
    run_div("b2b_second", 32'd2);
    tick;

    // Reset in the middle of a divide
    issue(mk(ALU_ADD, 1, 0, 0, 0, 0, 1, 32'd100, 32'd7, 32'd0));
    for (int i = 0; i < 10; i++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("rstdiv_valid", 32'(es_to_ms_valid), 32'd0);
    chk("rstdiv_allowin", 32'(es_allowin), 32'd1);
    issue(mk(ALU_ADD, 0, 0, 0, 0, 0, 1, 32'd2, 32'd3, 32'd0));
    chk("rstdiv_add_valid", 32'(es_to_ms_valid), 32'd1);
    chk("rstdiv_add_result", es_to_ms_bus[63:32], 32'd5);
    issue(mk(ALU_ADD, 1, 0, 0, 0, 0, 1, 32'd100, 32'd7, 32'd0));
    run_div("rstdiv_divu", 32'd14);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
